// File: rtl/display_sel_ctrl_if.sv
// Board-side signal bundle for the debug display selector.
// master drives the raw buttons and switch; slave produces the page select and step pulse.
interface display_sel_ctrl_if;
    logic       btn_next_n;
    logic       btn_prev_n;
    logic       btn_step_n;
    logic       auto_en;
    logic [3:0] sel;
    logic       step_pulse;
    logic [2:0] btn_state;

    modport master (
        output btn_next_n,
        output btn_prev_n,
        output btn_step_n,
        output auto_en,
        input  sel,
        input  step_pulse,
        input  btn_state
    );

    modport slave (
        input  btn_next_n,
        input  btn_prev_n,
        input  btn_step_n,
        input  auto_en,
        output sel,
        output step_pulse,
        output btn_state
    );
endinterface

// File: rtl/display_sel_ctrl.sv
// Debug display front end: synchronizes and debounces board buttons, then
// steps the pc_display page select manually or on an auto-cycle timer.
module display_sel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    display_sel_ctrl_if.slave  bus
);

    localparam int unsigned N_BTN    = 3;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned IDX_NEXT = 0;
    localparam int unsigned IDX_PREV = 1;
    localparam int unsigned IDX_STEP = 2;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CYCLES - 1);

    logic [N_BTN-1:0]            w_btn_raw_n;
    logic [N_BTN-1:0]            w_btn_act;
    logic [N_BTN-1:0]            r_btn_s1_n;
    logic [N_BTN-1:0]            r_btn_s2_n;
    logic                        r_auto_s1;
    logic                        r_auto_s2;

    logic [N_BTN-1:0]            r_stb;
    logic [N_BTN-1:0]            r_stb_d;
    logic [N_BTN-1:0]            r_evt;
    logic [N_BTN-1:0][CNT_W-1:0] r_db_cnt;

    logic [CNT_W-1:0]            r_auto_cnt;
    logic                        r_tick;
    logic [SEL_W-1:0]            r_sel;

    logic                        w_evt_next;
    logic                        w_evt_prev;
    logic                        w_manual;

    assign w_btn_raw_n = {bus.btn_step_n, bus.btn_prev_n, bus.btn_next_n};

    // Two-flop synchronizers; buttons idle released, switch idles off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1_n <= '1;
            r_btn_s2_n <= '1;
            r_auto_s1  <= 1'b0;
            r_auto_s2  <= 1'b0;
        end else begin
            r_btn_s1_n <= w_btn_raw_n;
            r_btn_s2_n <= r_btn_s1_n;
            r_auto_s1  <= bus.auto_en;
            r_auto_s2  <= r_auto_s1;
        end
    end

    // Stable state is kept in pressed polarity so btn_state is a plain register.
    assign w_btn_act = ~r_btn_s2_n;

    // Per-button debounce plus a one-cycle press event, one cycle after stb rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb    <= '0;
            r_stb_d  <= '0;
            r_evt    <= '0;
            r_db_cnt <= '0;
        end else begin
            r_stb_d <= r_stb;
            r_evt   <= r_stb & ~r_stb_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (w_btn_act[i] == r_stb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stb[i]    <= w_btn_act[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_evt_next = r_evt[IDX_NEXT];
    assign w_evt_prev = r_evt[IDX_PREV];
    assign w_manual   = w_evt_next | w_evt_prev;

    // Auto timer restarts on any manual page move so the next tick is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (!r_auto_s2 || w_manual) begin
            r_auto_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_auto_cnt == AUTO_LAST) begin
            r_auto_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_auto_cnt <= r_auto_cnt + CNT_W'(1);
            r_tick     <= 1'b0;
        end
    end

    // Page select: simultaneous next/prev cancel; a manual move swallows a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (w_evt_next && !w_evt_prev) begin
            r_sel <= r_sel + SEL_W'(1);
        end else if (w_evt_prev && !w_evt_next) begin
            r_sel <= r_sel - SEL_W'(1);
        end else if (!w_manual && r_tick) begin
            r_sel <= r_sel + SEL_W'(1);
        end
    end

    assign bus.sel        = r_sel;
    assign bus.step_pulse = r_evt[IDX_STEP];
    assign bus.btn_state  = r_stb;

endmodule

// File: tb/tb_display_sel_ctrl.sv
// Self-checking bench for display_sel_ctrl: directed vector table, hand-timed
// corner sequences and randomized stimulus compared against a behavioural model.
module tb_display_sel_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned A = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_sel_ctrl_if bus ();

    display_sel_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .AUTO_CYCLES     (A),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit mdl_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stb flips once the last D synchronized samples all disagree with it;
    // the auto tick fires A edges after the latest restart point.
    bit       m_s1 [4];
    bit       m_s2 [4];
    bit       m_hist [3][$];
    bit       m_stb [3];
    bit       m_stb_d [3];
    bit       m_evt [3];
    bit       m_tick;
    bit [3:0] m_sel;
    int       m_n;
    int       m_lr;

    always @(posedge clk or negedge rst_n) begin
        bit nx;
        bit pv;
        bit all_diff;
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 1'b1;  m_s2[b] = 1'b1;
                m_hist[b].delete();
                m_stb[b] = 1'b0; m_stb_d[b] = 1'b0; m_evt[b] = 1'b0;
            end
            m_s1[3] = 1'b0; m_s2[3] = 1'b0;
            m_tick = 1'b0; m_sel = 4'd0; m_n = 0; m_lr = 0;
        end else begin
            nx = m_evt[0];
            pv = m_evt[1];
            m_n++;
            if (nx && !pv)            m_sel = m_sel + 4'd1;
            else if (pv && !nx)       m_sel = m_sel - 4'd1;
            else if (!nx && !pv && m_tick) m_sel = m_sel + 4'd1;

            if (!m_s2[3] || nx || pv) begin
                m_lr = m_n; m_tick = 1'b0;
            end else if (m_n - m_lr == int'(A)) begin
                m_lr = m_n; m_tick = 1'b1;
            end else begin
                m_tick = 1'b0;
            end

            for (int b = 0; b < 3; b++) begin
                m_evt[b]   = m_stb[b] && !m_stb_d[b];
                m_stb_d[b] = m_stb[b];
                m_hist[b].push_back(!m_s2[b]);
                if (m_hist[b].size() > int'(D)) void'(m_hist[b].pop_front());
                all_diff = (m_hist[b].size() == int'(D));
                foreach (m_hist[b][k]) if (m_hist[b][k] == m_stb[b]) all_diff = 1'b0;
                if (all_diff) m_stb[b] = !m_stb[b];
            end

            m_s2 = m_s1;
            m_s1[0] = bus.btn_next_n; m_s1[1] = bus.btn_prev_n;
            m_s1[2] = bus.btn_step_n; m_s1[3] = bus.auto_en;
        end
    end

    always @(negedge clk) begin
        if (mdl_en && rst_n) begin
            check("mdl_sel", 32'(bus.sel), 32'(m_sel));
            check("mdl_step_pulse", 32'(bus.step_pulse), 32'(m_evt[2]));
            check("mdl_btn_state", 32'(bus.btn_state), 32'({m_stb[2], m_stb[1], m_stb[0]}));
        end
    end

    task automatic set_btn(input bit nx, input bit pv, input bit st);
        bus.btn_next_n = !nx;
        bus.btn_prev_n = !pv;
        bus.btn_step_n = !st;
    endtask

    task automatic press(input bit nx, input bit pv, input bit st, input int hold);
        @(negedge clk);
        set_btn(nx, pv, st);
        repeat (hold) @(negedge clk);
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
    endtask

    task automatic wait_sel_change(output int cycles);
        logic [3:0] s;
        s = bus.sel;
        cycles = 0;
        while (bus.sel == s && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 40) check("sel_change_timeout", 32'(cycles), 32'd0);
    endtask

    typedef struct {
        bit         nx;
        bit         pv;
        bit         st;
        int         hold;
        logic [2:0] exp_state;
        logic [3:0] exp_sel;
        int         exp_steps;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         c;
        int         steps;
        logic [3:0] s0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 3,  3'b000, 4'd0,  0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 20, 3'b001, 4'd1,  0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 10, 3'b010, 4'd0,  0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 10, 3'b010, 4'd15, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 10, 3'b011, 4'd15, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 10, 3'b100, 4'd15, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 3,  3'b000, 4'd15, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 10, 3'b100, 4'd15, 1};

        set_btn(1'b0, 1'b0, 1'b0);
        bus.auto_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_step_pulse", 32'(bus.step_pulse), 32'd0);
        check("rst_btn_state", 32'(bus.btn_state), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mdl_en = 1'b1;

        repeat (50) @(negedge clk);
        check("idle_sel", 32'(bus.sel), 32'd0);
        check("idle_btn_state", 32'(bus.btn_state), 32'd0);

        // Edge-accurate next press: stb at edge D+1, sel at edge D+3.
        @(negedge clk);
        set_btn(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("deb_state_e4", 32'(bus.btn_state[0]), 32'd0);
        @(negedge clk);
        check("deb_state_e5", 32'(bus.btn_state[0]), 32'd1);
        @(negedge clk);
        check("deb_sel_e6", 32'(bus.sel), 32'd0);
        @(negedge clk);
        check("deb_sel_e7", 32'(bus.sel), 32'd1);
        repeat (12) @(negedge clk);
        check("deb_hold_once", 32'(bus.sel), 32'd1);
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        press(1'b0, 1'b1, 1'b0, 10);
        check("back_to_zero", 32'(bus.sel), 32'd0);

        for (int k = 0; k < 8; k++) begin
            steps = 0;
            @(negedge clk);
            set_btn(vecs[k].nx, vecs[k].pv, vecs[k].st);
            repeat (vecs[k].hold) begin
                @(negedge clk);
                steps += int'(bus.step_pulse);
            end
            check($sformatf("vec%0d_btn_state", k), 32'(bus.btn_state), 32'(vecs[k].exp_state));
            set_btn(1'b0, 1'b0, 1'b0);
            repeat (14) begin
                @(negedge clk);
                steps += int'(bus.step_pulse);
            end
            check($sformatf("vec%0d_sel", k), 32'(bus.sel), 32'(vecs[k].exp_sel));
            check($sformatf("vec%0d_steps", k), 32'(steps), 32'(vecs[k].exp_steps));
        end

        for (int k = 0; k < 16; k++) begin
            press(1'b1, 1'b0, 1'b0, 8);
            check($sformatf("wrap_next%0d", k), 32'(bus.sel), 32'((15 + k + 1) % 16));
        end

        // Step pulse occupies exactly the cycle between edges D+2 and D+3.
        @(negedge clk);
        set_btn(1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("step_e5", 32'(bus.step_pulse), 32'd0);
        @(negedge clk);
        check("step_e6", 32'(bus.step_pulse), 32'd1);
        @(negedge clk);
        check("step_e7", 32'(bus.step_pulse), 32'd0);
        check("step_sel", 32'(bus.sel), 32'd15);
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);

        // Reset mid-press, then release reset with the button still held.
        @(negedge clk);
        set_btn(1'b1, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'(bus.sel), 32'd0);
        check("midrst_btn_state", 32'(bus.btn_state), 32'd0);
        check("midrst_step", 32'(bus.step_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        check("held_thru_rst_e6", 32'(bus.sel), 32'd0);
        @(negedge clk);
        check("held_thru_rst_e7", 32'(bus.sel), 32'd1);
        set_btn(1'b0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);

        // Auto mode: steady period, then manual presses at every phase of the period.
        @(negedge clk);
        bus.auto_en = 1'b1;
        wait_sel_change(c);
        for (int k = 0; k < 3; k++) begin
            s0 = bus.sel;
            wait_sel_change(c);
            check("auto_period", 32'(c), 32'(A));
            check("auto_incr", 32'(bus.sel), 32'(s0 + 4'd1));
        end
        for (int off = 0; off < 10; off++) begin
            wait_sel_change(c);
            repeat (off) @(negedge clk);
            press(1'b1, 1'b0, 1'b0, 6);
        end
        @(negedge clk);
        bus.auto_en = 1'b0;
        repeat (5) @(negedge clk);
        s0 = bus.sel;
        repeat (30) @(negedge clk);
        check("auto_off_frozen", 32'(bus.sel), 32'(s0));

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 99) < 3) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
                bus.btn_next_n = ($urandom_range(0, 2) != 0);
                bus.btn_prev_n = ($urandom_range(0, 2) != 0);
                bus.btn_step_n = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 7) == 0) bus.auto_en = !bus.auto_en;
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end

        mdl_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_sel_ctrl.md
# display_sel_ctrl

User-input front end for the processor debug display. It debounces three board push-buttons and a mode switch, then produces the 4-bit `sel` code consumed by `pc_display` (16 pages: PC, ALU result, instruction, rd, write data, rs1, mux outputs, each as a low or high half). It also produces a one-cycle `step_pulse` used as the single-step clock enable of the single-cycle core. In auto mode it cycles through the pages on a timer.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000. A synchronized input must differ from its debounced state for this many consecutive cycles before the state changes (10 ms at 50 MHz). Must be ≥ 2.
- `AUTO_CYCLES`, default 50000000. Clock cycles per page in auto mode (1 s at 50 MHz). Must be ≥ 2.
- `CNT_W`, default 26. Counter width; must hold `max(DEBOUNCE_CYCLES, AUTO_CYCLES)`.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_next_n`  in  1  raw push-button, active-low, asynchronous to `clk`. Advances the page.
- `btn_prev_n`  in  1  raw push-button, active-low, asynchronous. Moves back one page.
- `btn_step_n`  in  1  raw push-button, active-low, asynchronous. Single-step request.
- `auto_en`  in  1  slide switch, active-high, asynchronous. Enables auto-cycling.
- `sel`  out  4  page select to `pc_display`.
- `step_pulse`  out  1  one-cycle pulse per debounced step press.
- `btn_state`  out  3  debounced pressed flags `{step, prev, next}`, where 1 means pressed.

## Operation
- **Synchronizers.** Each of the four raw inputs passes through a 2-flop synchronizer. The button synchronizers reset to 1 (released). The `auto_en` synchronizer resets to 0.
- **Debouncer, one per button.** Holds a stable state `stb` and a counter.
  - When sync ≠ `stb`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while sync ≠ `stb`, `stb` takes the sync value and the counter clears.
  - When sync == `stb`, the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never changes `stb`.
- **Press event.** A registered one-cycle pulse, asserted on the cycle after `stb` goes released → pressed. Releases generate no event.
- **`step_pulse`.** Equal to the step press event register.
- **`sel` update.** `sel` is registered and updated on the edge following an event, with this priority:
  - next and prev events in the same cycle: no change.
  - next only: `sel+1`, wrapping 15 → 0.
  - prev only: `sel-1`, wrapping 0 → 15.
  - auto tick, with no manual event: `sel+1`, wrapping.
  - A manual event coincident with an auto tick wins. Exactly one change occurs and the tick is discarded.
- **Auto timer.**
  - Counts only while synchronized `auto_en` = 1.
  - At `AUTO_CYCLES-1` it issues a tick and clears.
  - It is cleared while `auto_en` = 0 and on any next/prev event, so the restart is a full period.
- **Steps.** Step events never affect `sel` or the auto timer.
- **Reset values.** `sel` = 0, `step_pulse` = 0, `btn_state` = 000. All counters are 0 and every `stb` = released. Assertion mid-count or mid-press aborts everything immediately. A button held through reset release produces a press event after `DEBOUNCE_CYCLES+2` cycles.

## Timing
- Number the edges from edge 0, the first edge at which raw = 0 is sampled.
- Synchronized value is 0 after edge 1.
- `stb` changes at edge `DEBOUNCE_CYCLES+1`. `btn_state` reflects `stb` directly.
- The event or `step_pulse` is high for exactly one cycle, from edge `DEBOUNCE_CYCLES+2` to the next edge.
- The new `sel` value is visible after edge `DEBOUNCE_CYCLES+3`.
- `auto_en` takes effect 2 cycles after the edge that samples it. The first auto tick comes `AUTO_CYCLES` cycles later, with `sel` updating one edge after the tick.
- Holding a button produces exactly one event. No auto-repeat.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4 and `AUTO_CYCLES`=10.
- **Reset.** Assert `rst_n`=0 asynchronously with buttons released → `sel`=0, `step_pulse`=0, `btn_state`=000. After release, nothing changes for 50 cycles.
- **Debounce.** Pulse `btn_next_n` low for 3 cycles, then high → `sel` stays 0. Hold it low for 20 cycles → `btn_state[0]`=1 after edge 5, and `sel`=1 after edge 7. Exactly one increment is required across the whole hold.
- **Wrap.** From `sel`=0, one prev press → `sel`=15. Sixteen next presses then return `sel` to 15.
- **Simultaneous.** Drive next and prev low on the same edge for 10 cycles → `sel` unchanged, and both `btn_state` bits are 1.
- **Step.** Press step for 10 cycles → `step_pulse` is high for exactly one cycle (edges 6–7) and `sel` is unchanged. Pulse width after re-press is also exactly one cycle.
- **Auto mode.** Set `auto_en`=1 → `sel` increments every 10 cycles (0 → 1 → 2 …). A next press mid-period yields one increment and restarts the 10-cycle period. An auto tick coincident with a manual event yields exactly one increment. `auto_en`=0 freezes `sel`.
